// File: rtl/color_centroid_pkg.sv
// Shared types for the colour-blob locator: FSM states, RGB565 pixel layout, threshold match.
package color_centroid_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, DIVIDE, DONE} state_t;

  typedef struct packed {
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
  } rgb565_t;

  // Inclusive per-channel window; an inverted window (lo > hi) can never match.
  function automatic logic rgb_match(input rgb565_t pix, input rgb565_t lo, input rgb565_t hi);
    return (pix.r5 >= lo.r5) && (pix.r5 <= hi.r5) &&
           (pix.g6 >= lo.g6) && (pix.g6 <= hi.g6) &&
           (pix.b5 >= lo.b5) && (pix.b5 <= hi.b5);
  endfunction

endpackage

// File: rtl/color_centroid_seq_divider.sv
// Restoring divider, one quotient bit per cycle; done pulses W cycles after start, no backpressure.
// Divide-by-zero yields 0; quotient holds until the next start.
module seq_divider #(
  parameter int W  = 8,
  parameter int QW = W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  dividend,
  input  logic [W-1:0]  divisor,
  output logic          done,
  output logic [QW-1:0] quotient
);

  localparam int CW = $clog2(W + 1);

  logic          busy;
  logic [CW-1:0] step;
  logic [W-1:0]  rem;
  logic [W-1:0]  quo;
  logic [W-1:0]  dvs;
  logic [W:0]    trial;
  logic [W:0]    diff;

  // Dividend bits shift out of quo's MSB while quotient bits shift in at the LSB.
  assign trial    = {rem, quo[W-1]};
  assign diff     = trial - {1'b0, dvs};
  assign done     = busy && (step == CW'(W - 1));
  assign quotient = (dvs == '0) ? '0 : quo[QW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      step <= '0;
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      step <= '0;
      rem  <= '0;
      quo  <= dividend;
      dvs  <= divisor;
    end else if (busy) begin
      rem  <= diff[W] ? trial[W-1:0] : diff[W-1:0];
      quo  <= {quo[W-2:0], ~diff[W]};
      step <= step + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/color_centroid.sv
// RGB565 colour-blob centroid per frame; result SUM_W+2 cycles after the last beat (2 if nothing matched).
// tready drops while dividing; COLOR_CENTROID_BBOX_EN adds matched-pixel bounding-box outputs.
module color_centroid
  import color_centroid_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  localparam int XW    = $clog2(IMG_W),
  localparam int YW    = $clog2(IMG_H),
  localparam int CNT_W = $clog2(IMG_W * IMG_H + 1),
  localparam int SUM_W = CNT_W + ((XW > YW) ? XW : YW)
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [15:0]      s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tlast,
  input  logic [15:0]      thr_min,
  input  logic [15:0]      thr_max,
  output logic             result_valid,
  output logic             found,
  output logic [XW-1:0]    cx,
  output logic [YW-1:0]    cy,
  output logic [CNT_W-1:0] count,
  output logic             frame_err
`ifdef COLOR_CENTROID_BBOX_EN
  ,
  output logic [XW-1:0]    bbox_xmin,
  output logic [XW-1:0]    bbox_xmax,
  output logic [YW-1:0]    bbox_ymin,
  output logic [YW-1:0]    bbox_ymax
`endif
);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  state_t state, state_nxt;

  logic             hs, sof_beat, take, line_err, final_beat, pix_match, div_start;
  logic [XW-1:0]    x, px;
  logic [YW-1:0]    y, py;
  rgb565_t          thr_lo, thr_hi;
  logic             p_vld, p_clr, p_match, p_final;
  logic [XW-1:0]    p_x;
  logic [YW-1:0]    p_y;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SUM_W-1:0] sx, sx_nxt, sy, sy_nxt;
  logic             qx_done, qy_done;
  logic [XW-1:0]    qx;
  logic [YW-1:0]    qy;

  assign s_axis_tready = ((state == IDLE) || (state == ACTIVE)) && !result_valid;
  assign hs            = s_axis_tvalid && s_axis_tready;
  assign sof_beat      = hs && s_axis_tuser;
  assign take          = hs && (s_axis_tuser || (state == ACTIVE));
  assign px            = sof_beat ? '0 : x;
  assign py            = sof_beat ? '0 : y;
  assign line_err      = take && (s_axis_tlast != (px == X_LAST));
  assign final_beat    = take && !line_err && s_axis_tlast && (py == Y_LAST);
  // A start-of-frame beat is classified against the thresholds it latches.
  assign pix_match     = rgb_match(rgb565_t'(s_axis_tdata),
                                   sof_beat ? rgb565_t'(thr_min) : thr_lo,
                                   sof_beat ? rgb565_t'(thr_max) : thr_hi);

  always_comb begin
    cnt_nxt = cnt;
    sx_nxt  = sx;
    sy_nxt  = sy;
    if (p_vld) begin
      if (p_clr) begin
        cnt_nxt = '0;
        sx_nxt  = '0;
        sy_nxt  = '0;
      end
      if (p_match) begin
        cnt_nxt = cnt_nxt + CNT_W'(1);
        sx_nxt  = sx_nxt + SUM_W'(p_x);
        sy_nxt  = sy_nxt + SUM_W'(p_y);
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // First DIVIDE cycle still holds the final beat in the pipeline stage.
  always_comb begin
    state_nxt = state;
    div_start = 1'b0;
    case (state)
      IDLE, ACTIVE: begin
        if (take) begin
          if (line_err)        state_nxt = IDLE;
          else if (final_beat) state_nxt = DIVIDE;
          else                 state_nxt = ACTIVE;
        end
      end
      DIVIDE: begin
        if (p_final) begin
          if (cnt_nxt == '0) state_nxt = DONE;
          else               div_start = 1'b1;
        end else if (qx_done && qy_done) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      x <= '0;  y <= '0;
      thr_lo <= '0;  thr_hi <= '0;
      p_vld <= 1'b0;  p_clr <= 1'b0;  p_match <= 1'b0;  p_final <= 1'b0;
      p_x <= '0;  p_y <= '0;
      cnt <= '0;  sx <= '0;  sy <= '0;
      result_valid <= 1'b0;  frame_err <= 1'b0;
      found <= 1'b0;  cx <= '0;  cy <= '0;  count <= '0;
    end else begin
      frame_err    <= take && (line_err || (state == ACTIVE && s_axis_tuser));
      result_valid <= (state == DONE);
      p_vld   <= take && !line_err;
      p_clr   <= sof_beat;
      p_match <= pix_match;
      p_final <= final_beat;
      p_x     <= px;
      p_y     <= py;
      cnt <= cnt_nxt;
      sx  <= sx_nxt;
      sy  <= sy_nxt;
      if (sof_beat) begin
        thr_lo <= rgb565_t'(thr_min);
        thr_hi <= rgb565_t'(thr_max);
      end
      if (take && !line_err) begin
        if (s_axis_tlast) begin
          x <= '0;
          y <= py + YW'(1);
        end else begin
          x <= px + XW'(1);
          y <= py;
        end
      end
      if (state == DONE) begin
        found <= (cnt != '0);
        count <= cnt;
        cx    <= (cnt != '0) ? qx : '0;
        cy    <= (cnt != '0) ? qy : '0;
      end
    end
  end

  seq_divider #(.W(SUM_W), .QW(XW)) u_div_x (
    .clk(ACLK), .rst(ARESET), .start(div_start),
    .dividend(sx_nxt), .divisor(SUM_W'(cnt_nxt)),
    .done(qx_done), .quotient(qx)
  );

  seq_divider #(.W(SUM_W), .QW(YW)) u_div_y (
    .clk(ACLK), .rst(ARESET), .start(div_start),
    .dividend(sy_nxt), .divisor(SUM_W'(cnt_nxt)),
    .done(qy_done), .quotient(qy)
  );

`ifdef COLOR_CENTROID_BBOX_EN
  logic [XW-1:0] bx_lo, bx_hi, bx_lo_nxt, bx_hi_nxt;
  logic [YW-1:0] by_lo, by_hi, by_lo_nxt, by_hi_nxt;

  always_comb begin
    bx_lo_nxt = bx_lo;  bx_hi_nxt = bx_hi;
    by_lo_nxt = by_lo;  by_hi_nxt = by_hi;
    if (p_vld && p_match) begin
      if (p_clr || (cnt == '0)) begin
        bx_lo_nxt = p_x;  bx_hi_nxt = p_x;
        by_lo_nxt = p_y;  by_hi_nxt = p_y;
      end else begin
        if (p_x < bx_lo) bx_lo_nxt = p_x;
        if (p_x > bx_hi) bx_hi_nxt = p_x;
        if (p_y < by_lo) by_lo_nxt = p_y;
        if (p_y > by_hi) by_hi_nxt = p_y;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      bx_lo <= '0;  bx_hi <= '0;  by_lo <= '0;  by_hi <= '0;
      bbox_xmin <= '0;  bbox_xmax <= '0;  bbox_ymin <= '0;  bbox_ymax <= '0;
    end else begin
      bx_lo <= bx_lo_nxt;  bx_hi <= bx_hi_nxt;
      by_lo <= by_lo_nxt;  by_hi <= by_hi_nxt;
      if (state == DONE) begin
        bbox_xmin <= (cnt != '0) ? bx_lo : '0;
        bbox_xmax <= (cnt != '0) ? bx_hi : '0;
        bbox_ymin <= (cnt != '0) ? by_lo : '0;
        bbox_ymax <= (cnt != '0) ? by_hi : '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_color_centroid.sv
// Scoreboard bench for color_centroid on an 8x4 image: directed frames, errors, restart and reset.
module tb_color_centroid;

  localparam int IMG_W    = 8;
  localparam int IMG_H    = 4;
  localparam int XW       = $clog2(IMG_W);
  localparam int YW       = $clog2(IMG_H);
  localparam int CNT_W    = $clog2(IMG_W * IMG_H + 1);
  localparam int SUM_W    = CNT_W + ((XW > YW) ? XW : YW);
  localparam int DIV_LAT  = SUM_W + 2;
  localparam int ZERO_LAT = 2;
  localparam logic [15:0] RED = 16'hF800;
  localparam logic [15:0] BLK = 16'h0000;

  logic             ACLK = 1'b0;
  logic             ARESET;
  logic [15:0]      s_axis_tdata;
  logic             s_axis_tvalid, s_axis_tready, s_axis_tuser, s_axis_tlast;
  logic [15:0]      thr_min, thr_max;
  logic             result_valid, found, frame_err;
  logic [XW-1:0]    cx;
  logic [YW-1:0]    cy;
  logic [CNT_W-1:0] count;
`ifdef COLOR_CENTROID_BBOX_EN
  logic [XW-1:0]    bbox_xmin, bbox_xmax;
  logic [YW-1:0]    bbox_ymin, bbox_ymax;
`endif

  color_centroid #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .thr_min(thr_min), .thr_max(thr_max),
    .result_valid(result_valid), .found(found), .cx(cx), .cy(cy), .count(count),
    .frame_err(frame_err)
`ifdef COLOR_CENTROID_BBOX_EN
    , .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax), .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax)
`endif
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  typedef struct { int cnt; int cx; int cy; int fnd; int at; } exp_t;
  exp_t res_q[$];
  exp_t mon_e;
  int   err_pending = 0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every result_valid / frame_err pulse must match a queued expectation.
  always @(negedge ACLK) begin
    if (ARESET === 1'b0) begin
      if (result_valid === 1'b1) begin
        if (res_q.size() == 0) begin
          chk("unexpected result_valid", 32'(result_valid), 0);
        end else begin
          mon_e = res_q.pop_front();
          chk("count", 32'(count), mon_e.cnt);
          chk("cx", 32'(cx), mon_e.cx);
          chk("cy", 32'(cy), mon_e.cy);
          chk("found", 32'(found), mon_e.fnd);
          chk("result latency cycle", cyc, mon_e.at);
          chk("tready during result", 32'(s_axis_tready), 0);
        end
      end
      if (frame_err === 1'b1) begin
        chk("frame_err expected", 32'(err_pending > 0), 1);
        if (err_pending > 0) err_pending--;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the handshake edge k.
  task automatic send(input logic [15:0] d, input bit u, input bit l, output int k);
    int w = 0;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (s_axis_tready !== 1'b1 && w < 100) begin
      @(negedge ACLK);
      w++;
    end
    if (s_axis_tready !== 1'b1) chk("tready wait", 32'(s_axis_tready), 1);
    k = cyc + 1;
    @(negedge ACLK);
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic frame(input logic [31:0] mask, input bit gap, input bit chg_thr,
                       input int ecnt, input int ecx, input int ecy, input bit push, input int lat);
    int k = 0;
    for (int y = 0; y < IMG_H; y++) begin
      for (int x = 0; x < IMG_W; x++) begin
        if (gap) repeat ($urandom_range(0, 2)) @(negedge ACLK);
        send(mask[y*IMG_W+x] ? RED : BLK, (x == 0 && y == 0), (x == IMG_W - 1), k);
        if (chg_thr && x == 0 && y == 0) thr_min = 16'hFFFF;
      end
    end
    if (push) res_q.push_back('{ecnt, ecx, ecy, (ecnt != 0) ? 1 : 0, k + lat});
    chk("tready low after final beat", 32'(s_axis_tready), 0);
    if (chg_thr) thr_min = RED;
  endtask

  task automatic drain();
    int w = 0;
    while ((res_q.size() != 0 || err_pending != 0) && w < 60) begin
      @(negedge ACLK);
      w++;
    end
    chk("outstanding expectations", res_q.size() + err_pending, 0);
  endtask

  initial begin
    int k;
    ARESET = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    thr_min = RED;
    thr_max = 16'hFFFF;
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("reset result_valid", 32'(result_valid), 0);
    chk("reset frame_err", 32'(frame_err), 0);
    chk("reset found", 32'(found), 0);
    chk("reset cx", 32'(cx), 0);
    chk("reset cy", 32'(cy), 0);
    chk("reset count", 32'(count), 0);
    chk("reset tready", 32'(s_axis_tready), 1);

    // Four red pixels at (2,1),(4,1),(2,3),(4,3); thr_min changes mid-frame but is latched.
    frame(32'h1400_1400, 0, 1, 4, 3, 2, 1, DIV_LAT);
    drain();
    // All black.
    frame(32'h0000_0000, 0, 0, 0, 0, 0, 1, ZERO_LAT);
    drain();
    // Inverted green window: nothing can match.
    thr_min = 16'hFFFF; thr_max = RED;
    frame(32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1, ZERO_LAT);
    drain();
    thr_min = RED; thr_max = 16'hFFFF;
    // All red with random tvalid gaps: 112/32 and 48/32 truncate.
    frame(32'hFFFF_FFFF, 1, 0, 32, 3, 1, 1, DIV_LAT);
    drain();

    // Early tlast at x=5 on line 1.
    for (int x = 0; x < IMG_W; x++) send(RED, x == 0, x == IMG_W - 1, k);
    err_pending++;
    for (int x = 0; x < 6; x++) send(RED, 1'b0, x == 5, k);
    drain();
    chk("held count", 32'(count), 32);
    chk("held cx", 32'(cx), 3);
    chk("held cy", 32'(cy), 1);
    chk("held found", 32'(found), 1);
    chk("idle tready", 32'(s_axis_tready), 1);
    // Missing tlast at x=7.
    err_pending++;
    for (int x = 0; x < IMG_W; x++) send(RED, x == 0, 1'b0, k);
    drain();
    // Stray non-SOF beats in IDLE are dropped.
    send(RED, 1'b0, 1'b0, k);
    send(RED, 1'b0, 1'b1, k);
    // Single red pixel on the very last beat.
    frame(32'h8000_0000, 0, 0, 1, 7, 3, 1, DIV_LAT);
    drain();

    // SOF arrives at the start of line 2: restart from that beat.
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < IMG_W; x++) send(RED, (x == 0 && y == 0), x == IMG_W - 1, k);
    err_pending++;
    frame(32'h0040_0001, 0, 0, 2, 3, 1, 1, DIV_LAT);
    drain();

    // Reset while dividing discards the frame.
    frame(32'h1400_1400, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge ACLK);
    ARESET = 1'b1;
    #1;
    chk("mid-divide reset count", 32'(count), 0);
    chk("mid-divide reset cx", 32'(cx), 0);
    chk("mid-divide reset cy", 32'(cy), 0);
    chk("mid-divide reset found", 32'(found), 0);
    chk("mid-divide reset result_valid", 32'(result_valid), 0);
    chk("mid-divide reset tready", 32'(s_axis_tready), 1);
    @(negedge ACLK);
    ARESET = 1'b0;
    repeat (SUM_W + 6) @(negedge ACLK);
    chk("count after reset", 32'(count), 0);
    frame(32'h1400_1400, 1, 0, 4, 3, 2, 1, DIV_LAT);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
